ct_ciu_vb_ebiu_sched: RTL and testbench



---
 rtl/ct_ciu_vb_ebiu_sched_if.sv | 29 ++
 rtl/ct_ciu_vb_ebiu_sched.sv | 186 ++++++++++++++++++
 tb/tb_ct_ciu_vb_ebiu_sched.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ct_ciu_vb_ebiu_sched_if.sv
// EBIU-facing AW/W request bus of the victim-buffer scheduler.
// The scheduler drives requests through the master modport and the EBIU returns grants through the slave modport.
interface ct_ciu_vb_ebiu_sched_if #(
   parameter int AWIDTH = 68,
   parameter int DWIDTH = 535,
   parameter int IDW    = 2
);
   logic              vb_ebiu_aw_vld;
   logic [AWIDTH-1:0] vb_ebiu_awbus;
   logic [2:0]        vb_ebiu_awmid;
   logic [IDW-1:0]    vb_ebiu_awid;
   logic              ebiu_vb_aw_grnt;
   logic              vb_ebiu_w_vld;
   logic [DWIDTH-1:0] vb_ebiu_wbus;
   logic [IDW-1:0]    vb_ebiu_wid;
   logic              ebiu_vb_w_grnt;

   modport master (
      output vb_ebiu_aw_vld, vb_ebiu_awbus, vb_ebiu_awmid, vb_ebiu_awid,
      output vb_ebiu_w_vld, vb_ebiu_wbus, vb_ebiu_wid,
      input  ebiu_vb_aw_grnt, ebiu_vb_w_grnt
   );

   modport slave (
      input  vb_ebiu_aw_vld, vb_ebiu_awbus, vb_ebiu_awmid, vb_ebiu_awid,
      input  vb_ebiu_w_vld, vb_ebiu_wbus, vb_ebiu_wid,
      output ebiu_vb_aw_grnt, ebiu_vb_w_grnt
   );
endinterface

// File: rtl/ct_ciu_vb_ebiu_sched.sv
// Victim-buffer downstream scheduler: round-robin AW issue to the EBIU, with
// W payloads returned strictly in AW order through an order FIFO.
module ct_ciu_vb_ebiu_sched #(
   parameter int ENTRY  = 4,
   parameter int IDW    = 2,
   parameter int AWIDTH = 68,
   parameter int DWIDTH = 535
) (
   input  logic                      vb_ctrl_clk,
   input  logic                      cpurst_b,
   input  logic [ENTRY-1:0]          vb_aw_en,
   input  logic [ENTRY-1:0]          vb_w_vld,
   input  logic [ENTRY*AWIDTH-1:0]   vb_awbus_flat,
   input  logic [ENTRY*3-1:0]        vb_mid_flat,
   input  logic [ENTRY*DWIDTH-1:0]   vb_wbus_flat,
   output logic [ENTRY-1:0]          vb_aw_req_sel,
   output logic [ENTRY-1:0]          vb_w_pop_sel,
   output logic                      vb_sched_idle,
   ct_ciu_vb_ebiu_sched_if.master    ebiu
);

   typedef enum logic {AW_IDLE, AW_REQ} aw_state_t;
   typedef enum logic {W_IDLE, W_SEND} w_state_t;

   localparam logic [IDW:0] DEPTH = (IDW+1)'(ENTRY);

   aw_state_t         aw_state_reg;
   w_state_t          w_state_reg;
   logic              aw_vld_reg;
   logic [AWIDTH-1:0] awbus_reg;
   logic [2:0]        awmid_reg;
   logic [IDW-1:0]    awid_reg;
   logic [IDW-1:0]    rr_ptr_reg;
   logic              w_vld_reg;
   logic [DWIDTH-1:0] wbus_reg;
   logic [IDW-1:0]    wid_reg;

   logic [IDW-1:0]    fifo_mem [ENTRY];
   logic [IDW-1:0]    fifo_wr_ptr_reg;
   logic [IDW-1:0]    fifo_rd_ptr_reg;
   logic [IDW:0]      fifo_cnt_reg;
   logic [IDW-1:0]    fifo_head;
   logic              fifo_push;
   logic              fifo_pop;

   logic [AWIDTH-1:0] awbus_arr [ENTRY];
   logic [2:0]        mid_arr   [ENTRY];
   logic [DWIDTH-1:0] wbus_arr  [ENTRY];
   logic              aw_found;
   logic [IDW-1:0]    aw_sel_idx;
   logic [IDW-1:0]    aw_cand;

   // Grants only count while the matching request is actually presented.
   assign fifo_push = aw_vld_reg & ebiu.ebiu_vb_aw_grnt;
   assign fifo_pop  = w_vld_reg  & ebiu.ebiu_vb_w_grnt;
   assign fifo_head = fifo_mem[fifo_rd_ptr_reg];

   genvar gi;
   generate
      for (gi = 0; gi < ENTRY; gi++) begin : g_entry
         assign awbus_arr[gi]     = vb_awbus_flat[gi*AWIDTH +: AWIDTH];
         assign mid_arr[gi]       = vb_mid_flat[gi*3 +: 3];
         assign wbus_arr[gi]      = vb_wbus_flat[gi*DWIDTH +: DWIDTH];
         assign vb_aw_req_sel[gi] = fifo_push & (awid_reg == IDW'(gi));
         assign vb_w_pop_sel[gi]  = fifo_pop  & (wid_reg  == IDW'(gi));
      end
   endgenerate

   // Search upward from the RR pointer; the first hit wins.
   always_comb begin
      aw_found   = 1'b0;
      aw_sel_idx = '0;
      aw_cand    = '0;
      for (int k = 0; k < ENTRY; k++) begin
         aw_cand = rr_ptr_reg + IDW'(k);
         if (!aw_found && vb_aw_en[aw_cand]) begin
            aw_found   = 1'b1;
            aw_sel_idx = aw_cand;
         end
      end
   end

   always_ff @(posedge vb_ctrl_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         aw_state_reg <= AW_IDLE;
         aw_vld_reg   <= 1'b0;
         awbus_reg    <= '0;
         awmid_reg    <= '0;
         awid_reg     <= '0;
         rr_ptr_reg   <= '0;
      end else begin
         case (aw_state_reg)
            AW_IDLE: begin
               if (aw_found && (fifo_cnt_reg != DEPTH)) begin
                  awbus_reg    <= awbus_arr[aw_sel_idx];
                  awmid_reg    <= mid_arr[aw_sel_idx];
                  awid_reg     <= aw_sel_idx;
                  aw_vld_reg   <= 1'b1;
                  aw_state_reg <= AW_REQ;
               end
            end
            AW_REQ: begin
               if (ebiu.ebiu_vb_aw_grnt) begin
                  aw_vld_reg   <= 1'b0;
                  rr_ptr_reg   <= awid_reg + IDW'(1);
                  aw_state_reg <= AW_IDLE;
               end
            end
            default: begin
               aw_vld_reg   <= 1'b0;
               aw_state_reg <= AW_IDLE;
            end
         endcase
      end
   end

   // Order storage needs no reset: only slots between rd and wr pointers are read.
   always_ff @(posedge vb_ctrl_clk) begin
      if (fifo_push) begin
         fifo_mem[fifo_wr_ptr_reg] <= awid_reg;
      end
   end

   always_ff @(posedge vb_ctrl_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         fifo_wr_ptr_reg <= '0;
         fifo_rd_ptr_reg <= '0;
         fifo_cnt_reg    <= '0;
      end else begin
         if (fifo_push) begin
            fifo_wr_ptr_reg <= fifo_wr_ptr_reg + IDW'(1);
         end
         if (fifo_pop) begin
            fifo_rd_ptr_reg <= fifo_rd_ptr_reg + IDW'(1);
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (IDW+1)'(1);
            2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (IDW+1)'(1);
            default: fifo_cnt_reg <= fifo_cnt_reg;
         endcase
      end
   end

   // Only the FIFO head may send W, so a late head blocks younger entries.
   always_ff @(posedge vb_ctrl_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         w_state_reg <= W_IDLE;
         w_vld_reg   <= 1'b0;
         wbus_reg    <= '0;
         wid_reg     <= '0;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               if ((fifo_cnt_reg != '0) && vb_w_vld[fifo_head]) begin
                  wbus_reg    <= wbus_arr[fifo_head];
                  wid_reg     <= fifo_head;
                  w_vld_reg   <= 1'b1;
                  w_state_reg <= W_SEND;
               end
            end
            W_SEND: begin
               if (ebiu.ebiu_vb_w_grnt) begin
                  w_vld_reg   <= 1'b0;
                  w_state_reg <= W_IDLE;
               end
            end
            default: begin
               w_vld_reg   <= 1'b0;
               w_state_reg <= W_IDLE;
            end
         endcase
      end
   end

   assign vb_sched_idle = (aw_state_reg == AW_IDLE) && (w_state_reg == W_IDLE) &&
                          (fifo_cnt_reg == '0);

   assign ebiu.vb_ebiu_aw_vld = aw_vld_reg;
   assign ebiu.vb_ebiu_awbus  = awbus_reg;
   assign ebiu.vb_ebiu_awmid  = awmid_reg;
   assign ebiu.vb_ebiu_awid   = awid_reg;
   assign ebiu.vb_ebiu_w_vld  = w_vld_reg;
   assign ebiu.vb_ebiu_wbus   = wbus_reg;
   assign ebiu.vb_ebiu_wid    = wid_reg;

endmodule

// File: tb/tb_ct_ciu_vb_ebiu_sched.sv
// Bench for ct_ciu_vb_ebiu_sched: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized VB traffic.
module tb_ct_ciu_vb_ebiu_sched;
   localparam int ENTRY  = 4;
   localparam int IDW    = 2;
   localparam int AWIDTH = 68;
   localparam int DWIDTH = 535;

   logic clk = 1'b0;
   logic cpurst_b = 1'b0;
   always #5 clk = ~clk;

   logic [ENTRY-1:0]        aw_en, w_vld_in, req_sel, pop_sel, e_alloc;
   logic                    idle;
   logic [AWIDTH-1:0]       e_aw  [ENTRY];
   logic [2:0]              e_mid [ENTRY];
   logic [DWIDTH-1:0]       e_w   [ENTRY];
   logic [ENTRY*AWIDTH-1:0] awbus_flat;
   logic [ENTRY*3-1:0]      mid_flat;
   logic [ENTRY*DWIDTH-1:0] wbus_flat;

   genvar gi;
   generate
      for (gi = 0; gi < ENTRY; gi++) begin : g_flat
         assign awbus_flat[gi*AWIDTH +: AWIDTH] = e_aw[gi];
         assign mid_flat[gi*3 +: 3]             = e_mid[gi];
         assign wbus_flat[gi*DWIDTH +: DWIDTH]  = e_w[gi];
      end
   endgenerate

   ct_ciu_vb_ebiu_sched_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .IDW(IDW)) ebiu_if ();

   ct_ciu_vb_ebiu_sched #(.ENTRY(ENTRY), .IDW(IDW), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
      .vb_ctrl_clk   (clk),
      .cpurst_b      (cpurst_b),
      .vb_aw_en      (aw_en),
      .vb_w_vld      (w_vld_in),
      .vb_awbus_flat (awbus_flat),
      .vb_mid_flat   (mid_flat),
      .vb_wbus_flat  (wbus_flat),
      .vb_aw_req_sel (req_sel),
      .vb_w_pop_sel  (pop_sel),
      .vb_sched_idle (idle),
      .ebiu          (ebiu_if)
   );

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   int both_cnt = 0;
   bit auto_mode = 1'b0;

   task automatic chk(input string nm, input logic [599:0] act, input logic [599:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Reference model: pending AW slot, pending W slot, and the issue order as a queue.
   bit m_aw_busy, m_w_busy;
   int m_awid, m_wid, m_rr;
   int m_q[$];

   always @(negedge clk) begin : model
      int qsz, head, pick;
      bit found;
      logic [ENTRY-1:0] exp_req, exp_pop;
      if (!cpurst_b) begin
         m_aw_busy = 1'b0; m_w_busy = 1'b0;
         m_awid = 0; m_wid = 0; m_rr = 0;
         m_q.delete();
      end else begin
         qsz  = m_q.size();
         head = (qsz > 0) ? m_q[0] : 0;
         exp_req = '0;
         exp_pop = '0;
         if (m_aw_busy && ebiu_if.ebiu_vb_aw_grnt) exp_req[m_awid] = 1'b1;
         if (m_w_busy && ebiu_if.ebiu_vb_w_grnt)   exp_pop[m_wid]  = 1'b1;
         chk("aw_vld", 600'(ebiu_if.vb_ebiu_aw_vld), 600'(m_aw_busy));
         if (m_aw_busy) begin
            chk("awid", 600'(ebiu_if.vb_ebiu_awid), 600'(m_awid));
            chk("awbus", 600'(ebiu_if.vb_ebiu_awbus), 600'(e_aw[m_awid]));
            chk("awmid", 600'(ebiu_if.vb_ebiu_awmid), 600'(e_mid[m_awid]));
         end
         chk("req_sel", 600'(req_sel), 600'(exp_req));
         chk("w_vld", 600'(ebiu_if.vb_ebiu_w_vld), 600'(m_w_busy));
         if (m_w_busy) begin
            chk("wid", 600'(ebiu_if.vb_ebiu_wid), 600'(m_wid));
            chk("wbus", 600'(ebiu_if.vb_ebiu_wbus), 600'(e_w[m_wid]));
         end
         chk("pop_sel", 600'(pop_sel), 600'(exp_pop));
         chk("idle", 600'(idle), 600'(!m_aw_busy && !m_w_busy && qsz == 0));
         if (|req_sel) chk("push_not_full", 600'(qsz < ENTRY), 600'(1));
         if (|pop_sel) chk("pop_not_empty", 600'(qsz > 0), 600'(1));
         if (|req_sel && |pop_sel) both_cnt++;

         if (m_aw_busy) begin
            if (ebiu_if.ebiu_vb_aw_grnt) begin
               m_q.push_back(m_awid);
               m_rr = (m_awid + 1) % ENTRY;
               m_aw_busy = 1'b0;
            end
         end else if (aw_en != '0 && qsz < ENTRY) begin
            found = 1'b0;
            pick = 0;
            for (int k = 0; k < ENTRY; k++) begin
               if (!found && aw_en[(m_rr + k) % ENTRY]) begin
                  found = 1'b1;
                  pick = (m_rr + k) % ENTRY;
               end
            end
            m_awid = pick;
            m_aw_busy = 1'b1;
         end
         if (m_w_busy) begin
            if (ebiu_if.ebiu_vb_w_grnt) begin
               void'(m_q.pop_front());
               m_w_busy = 1'b0;
            end
         end else if (qsz > 0 && w_vld_in[head]) begin
            m_wid = head;
            m_w_busy = 1'b1;
         end
      end
   end

   task automatic alloc_rand(input int i);
      for (int b = 0; b < AWIDTH; b++) e_aw[i][b] = 1'($urandom);
      for (int b = 0; b < DWIDTH; b++) e_w[i][b] = 1'($urandom);
      e_mid[i]   = 3'($urandom);
      e_alloc[i] = 1'b1;
      aw_en[i]   = 1'b1;
   endtask

   // One cycle of VB-side behaviour: strobed aw_en drops, popped entries free up.
   task automatic step();
      logic [ENTRY-1:0] cr, cp;
      @(negedge clk);
      cr = req_sel;
      cp = pop_sel;
      @(posedge clk);
      #1;
      ncyc++;
      for (int i = 0; i < ENTRY; i++) begin
         if (cr[i]) aw_en[i] = 1'b0;
         if (cp[i]) begin
            w_vld_in[i] = 1'b0;
            e_alloc[i]  = 1'b0;
         end
      end
      if (auto_mode) begin
         ebiu_if.ebiu_vb_aw_grnt = ($urandom_range(2) != 0);
         ebiu_if.ebiu_vb_w_grnt  = ($urandom_range(2) != 0);
         for (int i = 0; i < ENTRY; i++) begin
            if (!e_alloc[i] && $urandom_range(3) == 0) alloc_rand(i);
            else if (e_alloc[i] && !w_vld_in[i] && $urandom_range(2) == 0) w_vld_in[i] = 1'b1;
         end
      end
   endtask

   initial begin
      logic [15:0] seq;
      logic [AWIDTH-1:0] lit_aw;
      logic [DWIDTH-1:0] lit_w;
      int n, first, last, wcnt;
      aw_en = '0; w_vld_in = '0; e_alloc = '0;
      for (int i = 0; i < ENTRY; i++) begin
         e_aw[i] = '0; e_mid[i] = '0; e_w[i] = '0;
      end
      ebiu_if.ebiu_vb_aw_grnt = 1'b0;
      ebiu_if.ebiu_vb_w_grnt  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_aw_vld", 600'(ebiu_if.vb_ebiu_aw_vld), 600'(0));
      chk("rst_w_vld", 600'(ebiu_if.vb_ebiu_w_vld), 600'(0));
      chk("rst_idle", 600'(idle), 600'(1));
      chk("rst_awbus", 600'(ebiu_if.vb_ebiu_awbus), 600'(0));
      chk("rst_wbus", 600'(ebiu_if.vb_ebiu_wbus), 600'(0));
      chk("rst_strobes", 600'({req_sel, pop_sel}), 600'(0));
      cpurst_b = 1'b1;

      // Round robin from reset: all four pending, AW grant always high.
      for (int i = 0; i < ENTRY; i++) alloc_rand(i);
      ebiu_if.ebiu_vb_aw_grnt = 1'b1;
      seq = '0; n = 0; first = -1; last = -1;
      for (int s = 0; s < 14; s++) begin
         step();
         if (ebiu_if.vb_ebiu_aw_vld) begin
            seq = {seq[11:0], 2'b00, ebiu_if.vb_ebiu_awid};
            if (first < 0) first = ncyc;
            last = ncyc;
            n++;
         end
      end
      chk("rr_aw_seq", 600'(seq), 600'(16'h0123));
      chk("rr_aw_count", 600'(n), 600'(4));
      chk("rr_spacing", 600'(last - first), 600'(6));
      chk("rr_full_not_idle", 600'(idle), 600'(0));
      ebiu_if.ebiu_vb_aw_grnt = 1'b0;
      w_vld_in = '1;
      ebiu_if.ebiu_vb_w_grnt = 1'b1;
      seq = '0; n = 0;
      for (int s = 0; s < 14; s++) begin
         step();
         if (ebiu_if.vb_ebiu_w_vld) begin
            seq = {seq[11:0], 2'b00, ebiu_if.vb_ebiu_wid};
            n++;
         end
      end
      ebiu_if.ebiu_vb_w_grnt = 1'b0;
      chk("rr_w_seq", 600'(seq), 600'(16'h0123));
      chk("rr_w_count", 600'(n), 600'(4));
      chk("rr_drained_idle", 600'(idle), 600'(1));

      // Single entry 2 with 7 cycles of backpressure on each channel.
      lit_aw = 68'hA_BCDE_F012_3456_789A;
      lit_w = '0;
      lit_w[31:0] = 32'hC0DE_0002;
      lit_w[534:503] = 32'h5A5A_A5A5;
      e_aw[2] = lit_aw; e_mid[2] = 3'd5; e_w[2] = lit_w;
      e_alloc[2] = 1'b1; aw_en = 4'b0100;
      step();
      chk("s_aw_vld", 600'(ebiu_if.vb_ebiu_aw_vld), 600'(1));
      chk("s_awid", 600'(ebiu_if.vb_ebiu_awid), 600'(2));
      chk("s_awbus", 600'(ebiu_if.vb_ebiu_awbus), 600'(lit_aw));
      chk("s_awmid", 600'(ebiu_if.vb_ebiu_awmid), 600'(5));
      for (int s = 0; s < 7; s++) begin
         step();
         chk("s_aw_hold", 600'({ebiu_if.vb_ebiu_aw_vld, ebiu_if.vb_ebiu_awid, ebiu_if.vb_ebiu_awbus}),
             600'({1'b1, 2'd2, lit_aw}));
         chk("s_aw_no_sel", 600'(req_sel), 600'(0));
      end
      ebiu_if.ebiu_vb_aw_grnt = 1'b1;
      #1;
      chk("s_req_sel", 600'(req_sel), 600'(4'b0100));
      step();
      ebiu_if.ebiu_vb_aw_grnt = 1'b0;
      chk("s_aw_done", 600'({ebiu_if.vb_ebiu_aw_vld, req_sel}), 600'(0));
      w_vld_in[2] = 1'b1;
      step();
      chk("s_w_vld", 600'(ebiu_if.vb_ebiu_w_vld), 600'(1));
      chk("s_wid", 600'(ebiu_if.vb_ebiu_wid), 600'(2));
      chk("s_wbus", 600'(ebiu_if.vb_ebiu_wbus), 600'(lit_w));
      for (int s = 0; s < 7; s++) begin
         step();
         chk("s_w_hold", 600'({ebiu_if.vb_ebiu_w_vld, ebiu_if.vb_ebiu_wid, ebiu_if.vb_ebiu_wbus}),
             600'({1'b1, 2'd2, lit_w}));
         chk("s_w_no_pop", 600'(pop_sel), 600'(0));
      end
      ebiu_if.ebiu_vb_w_grnt = 1'b1;
      #1;
      chk("s_pop_sel", 600'(pop_sel), 600'(4'b0100));
      step();
      ebiu_if.ebiu_vb_w_grnt = 1'b0;
      chk("s_idle_after", 600'({idle, ebiu_if.vb_ebiu_w_vld}), 600'(2'b10));

      // Order: RR pointer sits at 3, so AW goes 3 then 1; W of 1 is ready first but must wait.
      alloc_rand(1); alloc_rand(3);
      w_vld_in[1] = 1'b1;
      ebiu_if.ebiu_vb_aw_grnt = 1'b1;
      ebiu_if.ebiu_vb_w_grnt  = 1'b1;
      seq = '0; wcnt = 0;
      for (int s = 0; s < 15; s++) begin
         step();
         if (ebiu_if.vb_ebiu_aw_vld) seq = {seq[11:0], 2'b00, ebiu_if.vb_ebiu_awid};
         if (ebiu_if.vb_ebiu_w_vld) wcnt++;
      end
      chk("ord_aw_seq", 600'(seq), 600'(16'h0031));
      chk("ord_no_early_w", 600'(wcnt), 600'(0));
      w_vld_in[3] = 1'b1;
      seq = '0; n = 0;
      for (int s = 0; s < 15; s++) begin
         step();
         if (ebiu_if.vb_ebiu_w_vld) begin
            seq = {seq[11:0], 2'b00, ebiu_if.vb_ebiu_wid};
            n++;
         end
      end
      chk("ord_w_seq", 600'(seq), 600'(16'h0031));
      chk("ord_w_count", 600'(n), 600'(2));
      ebiu_if.ebiu_vb_aw_grnt = 1'b0;
      ebiu_if.ebiu_vb_w_grnt  = 1'b0;
      step();
      chk("ord_idle", 600'(idle), 600'(1));

      // Randomized traffic, then drain everything still in flight.
      auto_mode = 1'b1;
      repeat (3000) step();
      auto_mode = 1'b0;
      ebiu_if.ebiu_vb_aw_grnt = 1'b1;
      ebiu_if.ebiu_vb_w_grnt  = 1'b1;
      for (int s = 0; s < 80; s++) begin
         w_vld_in = w_vld_in | e_alloc;
         step();
      end
      chk("rand_drain_idle", 600'(idle), 600'(1));
      chk("rand_both_strobes_seen", 600'(both_cnt > 0), 600'(1));

      // Reset while AW_REQ and W_SEND are both active.
      ebiu_if.ebiu_vb_aw_grnt = 1'b0;
      ebiu_if.ebiu_vb_w_grnt  = 1'b0;
      alloc_rand(0); alloc_rand(1);
      w_vld_in = 4'b0011;
      step();
      ebiu_if.ebiu_vb_aw_grnt = 1'b1;
      step();
      ebiu_if.ebiu_vb_aw_grnt = 1'b0;
      step();
      chk("pre_rst_busy", 600'({ebiu_if.vb_ebiu_aw_vld, ebiu_if.vb_ebiu_w_vld}), 600'(2'b11));
      cpurst_b = 1'b0;
      ebiu_if.ebiu_vb_aw_grnt = 1'b1;
      ebiu_if.ebiu_vb_w_grnt  = 1'b1;
      #1;
      chk("rst_mid_vlds", 600'({ebiu_if.vb_ebiu_aw_vld, ebiu_if.vb_ebiu_w_vld}), 600'(0));
      chk("rst_mid_strobes", 600'({req_sel, pop_sel}), 600'(0));
      chk("rst_mid_idle", 600'(idle), 600'(1));
      step();
      aw_en = '0; w_vld_in = '0; e_alloc = '0;
      ebiu_if.ebiu_vb_aw_grnt = 1'b0;
      ebiu_if.ebiu_vb_w_grnt  = 1'b0;
      step();
      cpurst_b = 1'b1;
      step();
      chk("rst_release_idle", 600'(idle), 600'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
